// File: rtl/s2mm_frame_pkg.sv
// Shared types and sizing helpers for the S2MM frame packer and its FIFO.
package s2mm_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam int DATA_W_DEF     = 32;
    localparam int FIFO_DEPTH_DEF = 16;

    localparam int KEEP_W = DATA_W_DEF / 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH_DEF);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Parameterised forms of KEEP_W / PTR_W for instances that override the defaults.
    function automatic int keep_width(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; the head entry is always visible on rd_data.
module sync_fifo_fwft
    import s2mm_frame_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        rd_en,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        full,
    output logic                        empty,
    output logic [ptr_width(DEPTH):0]   count
);

    localparam int PW = ptr_width(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW:0]       wr_ptr_q, wr_ptr_d;
    logic [PW:0]       rd_ptr_q, rd_ptr_d;
    logic              do_wr;
    logic              do_rd;

    // Full/empty come from the registered pointers, so a write into a full FIFO is lost
    // even when a read frees a slot in the same cycle.
    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        full     = (count == DEPTH_C);
        empty    = (count == '0);
        do_wr    = wr_en & ~full;
        do_rd    = rd_en & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + (PW + 1)'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + (PW + 1)'(1);
        end
        rd_data = mem_q[rd_ptr_q[PW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[PW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/s2mm_frame_packer.sv
// Captures an armed number of FRAME_LEN-beat frames from a sample stream into AXI4-Stream,
// buffering through a small FIFO and counting samples lost to overflow.
module s2mm_frame_packer
    import s2mm_frame_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FRAME_LEN  = 1024,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DATA_W-1:0]               in_data,
    input  logic                            in_valid,
    input  logic                            arm,
    input  logic [15:0]                     frames_req,
    output logic [DATA_W-1:0]               m_axis_tdata,
    output logic [keep_width(DATA_W)-1:0]   m_axis_tkeep,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            busy,
    output logic                            done,
    output logic [15:0]                     drop_cnt
);

    localparam int PW     = ptr_width(FIFO_DEPTH);
    localparam int BEAT_W = $clog2(FRAME_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(FRAME_LEN - 1);
    localparam logic [31:0]       FRAME_LEN_C = 32'(FRAME_LEN);

    state_t             state_q, state_d;
    logic [15:0]        frames_q, frames_d;
    logic [31:0]        target_q, target_d;
    logic [31:0]        in_cnt_q, in_cnt_d;
    logic [BEAT_W-1:0]  out_beat_q, out_beat_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               fifo_wr_en;
    logic [DATA_W-1:0]  fifo_rd_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic [PW:0]        fifo_count;
    logic               hs;
    logic               last_beat;

    sync_fifo_fwft #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr_en),
        .wr_data (in_data),
        .rd_en   (m_axis_tready),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        frames_d    = frames_q;
        target_d    = target_q;
        in_cnt_d    = in_cnt_q;
        out_beat_d  = out_beat_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        done_d      = 1'b0;
        fifo_wr_en  = 1'b0;

        hs        = ~fifo_empty & m_axis_tready;
        last_beat = (out_beat_q == LAST_BEAT);

        if (hs) begin
            if (last_beat) begin
                out_beat_d  = '0;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
                out_beat_d  = out_beat_q + BEAT_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (arm) begin
                    if (frames_req == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = RUN;
                        frames_d    = frames_req;
                        target_d    = 32'(frames_req) * FRAME_LEN_C;
                        in_cnt_d    = '0;
                        out_beat_d  = '0;
                        frame_cnt_d = '0;
                        drop_cnt_d  = '0;
                    end
                end
            end
            // Dropped samples do not advance in_cnt, so every frame stays full-length.
            RUN: begin
                if (in_valid) begin
                    if (!fifo_full) begin
                        fifo_wr_en = 1'b1;
                        in_cnt_d   = in_cnt_q + 32'd1;
                        if (in_cnt_d == target_q) begin
                            state_d = DRAIN;
                        end
                    end else if (drop_cnt_q != CNT_MAX) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end
                end
            end
            DRAIN: begin
                if (hs && last_beat && (frame_cnt_q == frames_q - 16'd1)
                    && (fifo_count == (PW + 1)'(1))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            frames_q    <= '0;
            target_q    <= '0;
            in_cnt_q    <= '0;
            out_beat_q  <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frames_q    <= frames_d;
            target_q    <= target_d;
            in_cnt_q    <= in_cnt_d;
            out_beat_q  <= out_beat_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign m_axis_tvalid = ~fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0 : fifo_rd_data;
    assign m_axis_tlast  = ~fifo_empty & last_beat;
    assign m_axis_tkeep  = '1;
    assign busy          = busy_q;
    assign done          = done_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_s2mm_frame_packer.sv
// Self-checking bench for s2mm_frame_packer: a queue-based reference model, a hand-derived
// vector table for one frame, and directed sequences for backpressure, arm and reset cases.
module tb_s2mm_frame_packer;

    localparam int DATA_W     = 32;
    localparam int FRAME_LEN  = 4;
    localparam int FIFO_DEPTH = 4;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              arm;
    logic [15:0]       frames_req;
    logic [DATA_W-1:0] m_axis_tdata;
    logic [3:0]        m_axis_tkeep;
    logic              m_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              busy;
    logic              done;
    logic [15:0]       drop_cnt;

    s2mm_frame_packer #(
        .DATA_W     (DATA_W),
        .FRAME_LEN  (FRAME_LEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .arm           (arm),
        .frames_req    (frames_req),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .done          (done),
        .drop_cnt      (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the FIFO is a queue, the capture is tracked as samples still to accept
    // and beats still to emit.
    logic [31:0] mq [$];
    int          accept_left = 0;
    int          beats_left  = 0;
    int          emitted     = 0;
    logic [15:0] m_drop      = 0;
    bit          m_done      = 0;

    logic [31:0] data_ctr   = 0;
    int          beat_cnt   = 0;
    int          last_cnt   = 0;
    int          gaps       = 0;
    logic [31:0] first_data = 0;

    typedef struct {
        bit          arm;
        logic [15:0] fr;
        bit          rdy;
        bit          e_valid;
        logic [31:0] e_data;
        bit          e_last;
        bit          e_busy;
        bit          e_done;
        logic [15:0] e_drop;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic modelStep(input bit a, input logic [15:0] fr, input bit v, input bit rdy,
                             input bit rn, input logic [31:0] d);
        bit hs;
        bit full;
        hs   = (mq.size() != 0) && rdy;
        full = (mq.size() == FIFO_DEPTH);
        if (!rn) begin
            mq.delete();
            accept_left = 0;
            beats_left  = 0;
            emitted     = 0;
            m_drop      = 0;
            m_done      = 0;
            return;
        end
        m_done = 0;
        if (beats_left == 0) begin
            if (a) begin
                if (fr == 0) begin
                    m_done = 1;
                end else begin
                    accept_left = int'(fr) * FRAME_LEN;
                    beats_left  = accept_left;
                    emitted     = 0;
                    m_drop      = 0;
                end
            end
        end else if (accept_left > 0 && v) begin
            if (full) begin
                if (m_drop != 16'hFFFF) m_drop++;
            end else begin
                mq.push_back(d);
                accept_left--;
            end
        end
        if (hs) begin
            void'(mq.pop_front());
            emitted++;
            beats_left--;
            if (beats_left == 0) m_done = 1;
        end
    endtask

    task automatic checkOutput();
        bit exp_valid;
        bit exp_last;
        exp_valid = (mq.size() != 0);
        exp_last  = exp_valid && ((emitted % FRAME_LEN) == FRAME_LEN - 1);
        check("tvalid", 32'(m_axis_tvalid), 32'(exp_valid));
        check("tlast", 32'(m_axis_tlast), 32'(exp_last));
        check("busy", 32'(busy), 32'(beats_left != 0));
        check("done", 32'(done), 32'(m_done));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        check("tkeep", 32'(m_axis_tkeep), 32'h0000_000F);
        if (exp_valid) check("tdata", m_axis_tdata, mq[0]);
    endtask

    task automatic applyStimulus(input bit a, input logic [15:0] fr, input bit v, input bit rdy,
                                 input bit rn);
        arm           = a;
        frames_req    = fr;
        in_valid      = v;
        m_axis_tready = rdy;
        rst_n         = rn;
        in_data       = data_ctr;
        if (rn && busy && beat_cnt > 0 && !m_axis_tvalid) gaps++;
        if (rn && m_axis_tvalid && rdy) begin
            if (beat_cnt == 0) first_data = m_axis_tdata;
            check("tlast_position", 32'(m_axis_tlast), 32'((beat_cnt % FRAME_LEN) == FRAME_LEN - 1));
            beat_cnt++;
            if (m_axis_tlast) last_cnt++;
        end
        @(posedge clk);
        modelStep(a, fr, v, rdy, rn, data_ctr);
        data_ctr++;
        @(negedge clk);
        checkOutput();
    endtask

    task automatic clearCounts();
        beat_cnt = 0;
        last_cnt = 0;
        gaps     = 0;
    endtask

    // mode 0: tready high, mode 1: tready random, mode 2: tready and in_valid random
    task automatic runUntilDone(input int mode, input int max_cycles);
        bit seen;
        bit v;
        bit r;
        seen = 0;
        for (int i = 0; i < max_cycles; i++) begin
            v = (mode == 2) ? bit'($urandom_range(0, 1)) : 1'b1;
            r = (mode == 0) ? 1'b1 : bit'($urandom_range(0, 1));
            applyStimulus(1'b0, 16'd0, v, r, 1'b1);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        rst_n         = 1'b0;
        arm           = 1'b0;
        frames_req    = 16'd0;
        in_valid      = 1'b1;
        in_data       = '0;
        m_axis_tready = 1'b1;

        $display("[TB] reset");
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
        check("reset_tdata", m_axis_tdata, 32'h0);
        check("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_drop", 32'(drop_cnt), 32'd0);
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b1, 1'b1);

        $display("[TB] single frame table");
        //              arm fr     rdy val data         last busy done drop
        vecs[0] = '{1'b1, 16'd1, 1'b1, 1'b0, 32'h00,  1'b0, 1'b1, 1'b0, 16'd0};
        vecs[1] = '{1'b0, 16'd0, 1'b1, 1'b1, 32'h10,  1'b0, 1'b1, 1'b0, 16'd0};
        vecs[2] = '{1'b0, 16'd0, 1'b1, 1'b1, 32'h11,  1'b0, 1'b1, 1'b0, 16'd0};
        vecs[3] = '{1'b0, 16'd0, 1'b1, 1'b1, 32'h12,  1'b0, 1'b1, 1'b0, 16'd0};
        vecs[4] = '{1'b0, 16'd0, 1'b1, 1'b1, 32'h13,  1'b1, 1'b1, 1'b0, 16'd0};
        vecs[5] = '{1'b0, 16'd0, 1'b1, 1'b0, 32'h00,  1'b0, 1'b0, 1'b1, 16'd0};
        vecs[6] = '{1'b0, 16'd0, 1'b1, 1'b0, 32'h00,  1'b0, 1'b0, 1'b0, 16'd0};
        data_ctr = 32'h0F;
        clearCounts();
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].arm, vecs[i].fr, 1'b1, vecs[i].rdy, 1'b1);
            check($sformatf("vec%0d_tvalid", i), 32'(m_axis_tvalid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d_tlast", i), 32'(m_axis_tlast), 32'(vecs[i].e_last));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].e_done));
            check($sformatf("vec%0d_drop", i), 32'(drop_cnt), 32'(vecs[i].e_drop));
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_tdata", i), m_axis_tdata, vecs[i].e_data);
            end
        end
        check("single_beats", 32'(beat_cnt), 32'd4);
        check("single_lasts", 32'(last_cnt), 32'd1);

        $display("[TB] three frames continuous");
        clearCounts();
        applyStimulus(1'b1, 16'd3, 1'b1, 1'b1, 1'b1);
        runUntilDone(0, 100);
        check("three_beats", 32'(beat_cnt), 32'd12);
        check("three_lasts", 32'(last_cnt), 32'd3);
        check("three_gaps", 32'(gaps), 32'd0);

        $display("[TB] backpressure");
        clearCounts();
        applyStimulus(1'b1, 16'd2, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b1);
        check("bp_fifo_full_valid", 32'(m_axis_tvalid), 32'd1);
        check("bp_drop_mid", 32'(drop_cnt), 32'd5);
        runUntilDone(0, 100);
        check("bp_drop_final", 32'(drop_cnt), 32'd6);
        check("bp_beats", 32'(beat_cnt), 32'd8);
        check("bp_lasts", 32'(last_cnt), 32'd2);

        $display("[TB] arm with zero frames");
        applyStimulus(1'b1, 16'd0, 1'b1, 1'b1, 1'b1);
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        check("zero_drop_kept", 32'(drop_cnt), 32'd6);
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b1, 1'b1);
        check("zero_done_pulse", 32'(done), 32'd0);
        check("zero_no_beat", 32'(m_axis_tvalid), 32'd0);

        $display("[TB] arm during run");
        clearCounts();
        applyStimulus(1'b1, 16'd2, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 16'd5, 1'b1, 1'b1, 1'b1);
        check("rearm_busy", 32'(busy), 32'd1);
        runUntilDone(0, 100);
        check("rearm_beats", 32'(beat_cnt), 32'd8);
        check("rearm_lasts", 32'(last_cnt), 32'd2);

        $display("[TB] reset mid-frame");
        clearCounts();
        applyStimulus(1'b1, 16'd2, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 50; i++) begin
            if (beat_cnt >= 3) break;
            applyStimulus(1'b0, 16'd0, 1'b1, 1'b1, 1'b1);
        end
        check("rst_reached_beat2", 32'(beat_cnt), 32'd3);
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        clearCounts();
        applyStimulus(1'b1, 16'd1, 1'b1, 1'b1, 1'b1);
        begin
            logic [31:0] exp_first;
            exp_first = data_ctr;
            runUntilDone(0, 100);
            check("rst_fresh_first", first_data, exp_first);
        end
        check("rst_fresh_beats", 32'(beat_cnt), 32'd4);
        check("rst_fresh_lasts", 32'(last_cnt), 32'd1);

        $display("[TB] random stall");
        clearCounts();
        applyStimulus(1'b1, 16'd5, 1'b1, 1'b0, 1'b1);
        runUntilDone(1, 2000);
        check("stall_beats", 32'(beat_cnt), 32'd20);
        check("stall_lasts", 32'(last_cnt), 32'd5);

        $display("[TB] random valid and ready");
        for (int k = 0; k < 3; k++) begin
            logic [15:0] fr;
            fr = 16'($urandom_range(1, 3));
            clearCounts();
            applyStimulus(1'b1, fr, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b1);
            runUntilDone(2, 2000);
            check("rand_beats", 32'(beat_cnt), 32'(int'(fr) * FRAME_LEN));
            check("rand_lasts", 32'(last_cnt), 32'(fr));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
